// File: rtl/oam_dma_pkg.sv
// Shared types and address constants for the sprite DMA engine.
package oam_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam int          OAM_DMA_REG  = 'h14;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam int          IDX_N        = 8;
    localparam logic [7:0]  IDX_LAST     = 8'hFF;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a write of page P halts the CPU, then copies P*256..P*256+255
// to the sprite data port as alternating read/write bus cycles.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int                  PERIPH_N  = 8,
    parameter int                  ADDR_N    = 16,
    parameter int                  DATA_N    = 8,
    parameter logic [PERIPH_N-1:0] REG_ADDR  = PERIPH_N'(OAM_DMA_REG),
    parameter logic [ADDR_N-1:0]   DEST_ADDR = ADDR_N'(OAMDATA_ADDR)
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                periph_sel,
    input  logic                periph_we,
    input  logic [PERIPH_N-1:0] periph_addr,
    input  logic [DATA_N-1:0]   periph_data,
    input  logic                cpu_we,
    output logic                rdy,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_N-1:0]   bus_addr,
    output logic [DATA_N-1:0]   bus_dout,
    input  logic [DATA_N-1:0]   bus_din,
    output logic                busy
);

    dma_state_t         r_state;
    dma_state_t         w_state_nxt;
    logic [DATA_N-1:0]  r_page;
    logic [IDX_N-1:0]   r_idx;
    logic [DATA_N-1:0]  r_latch;
    logic               r_phase;
    logic               w_trig;

    assign w_trig = periph_sel & periph_we & (periph_addr == REG_ADDR);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Page/index/latch update; phase is the free-running CPU cycle parity.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_page  <= '0;
            r_idx   <= '0;
            r_latch <= '0;
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (r_state == IDLE && w_trig) begin
                r_page <= periph_data;
                r_idx  <= '0;
            end
            if (r_state == READ) begin
                r_latch <= bus_din;
            end
            if (r_state == WRITE) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    // Outputs depend on registered state only, never on inputs.
    always_comb begin
        w_state_nxt = r_state;
        rdy         = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_dout    = '0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                rdy  = 1'b1;
                busy = 1'b0;
                if (w_trig) w_state_nxt = HALT;
            end
            HALT: begin
                // The CPU ignores RDY during writes, so wait them out.
                if (!cpu_we) w_state_nxt = r_phase ? READ : ALIGN;
            end
            ALIGN: begin
                w_state_nxt = READ;
            end
            READ: begin
                bus_req     = 1'b1;
                bus_addr    = ADDR_N'({r_page, r_idx});
                w_state_nxt = WRITE;
            end
            WRITE: begin
                bus_req     = 1'b1;
                bus_we      = 1'b1;
                bus_addr    = DEST_ADDR;
                bus_dout    = r_latch;
                w_state_nxt = (r_idx == IDX_LAST) ? IDLE : READ;
            end
            default: begin
                rdy         = 1'b1;
                busy        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected bus traffic is queued per trigger
// from a memory model, and a negedge monitor pops and compares it.
module tb_oam_dma;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        periph_sel, periph_we, cpu_we;
    logic [7:0]  periph_addr, periph_data;
    logic        rdy, bus_req, bus_we, busy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout, bus_din;

    logic [7:0]  mem [0:65535];
    txn_t        exp_q[$];
    txn_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          pops = 0;
    int          cyc = 0;
    int          first_read_cyc = -1;
    int          len;

    always #5 clk = ~clk;

    oam_dma dut (
        .clk(clk), .n_reset(n_reset),
        .periph_sel(periph_sel), .periph_we(periph_we),
        .periph_addr(periph_addr), .periph_data(periph_data),
        .cpu_we(cpu_we), .rdy(rdy), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
        .busy(busy)
    );

    assign bus_din = mem[bus_addr];

    // Cycles since reset release; its parity is the expected CPU phase.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (n_reset) begin
            if (bus_req) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_bus: we=%0b addr=%0h dout=%0h", bus_we, bus_addr, bus_dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("bus_we", {31'd0, bus_we}, {31'd0, mon_e.we});
                    check("bus_addr", {16'd0, bus_addr}, {16'd0, mon_e.addr});
                    check("bus_dout", {24'd0, bus_dout}, {24'd0, mon_e.data});
                    if (first_read_cyc < 0) first_read_cyc = cyc;
                    pops++;
                end
            end else begin
                check("idle_addr", {16'd0, bus_addr}, 32'd0);
                check("idle_dout", {24'd0, bus_dout}, 32'd0);
            end
        end
    end

    task automatic push_xfer(input logic [7:0] page);
        txn_t t;
        for (int i = 0; i < 256; i++) begin
            t.we = 1'b0; t.addr = {page, 8'(i)}; t.data = 8'h00;
            exp_q.push_back(t);
            t.we = 1'b1; t.addr = 16'h2004; t.data = mem[{page, 8'(i)}];
            exp_q.push_back(t);
        end
    endtask

    task automatic periph_idle();
        periph_sel = 1'b0; periph_we = 1'b0; periph_addr = 8'($urandom); periph_data = 8'($urandom);
    endtask

    // One full transfer; returns the measured number of rdy-low cycles.
    task automatic xfer(input logic [7:0] page, input int stall, input int want_par,
                        input bit retrig, output int rdy_low);
        int t, a, exp_len;
        bit exp_b;
        @(negedge clk);
        if (want_par >= 0) while (((cyc + 1) % 2) != want_par) @(negedge clk);
        periph_sel = 1'b1; periph_we = 1'b1; periph_addr = 8'h14; periph_data = page;
        push_xfer(page);
        first_read_cyc = -1;
        @(posedge clk); #1;
        t = cyc;
        periph_idle();
        cpu_we = (stall > 0);
        check("rdy_fall", {31'd0, rdy}, 32'd0);
        for (int k = 0; k < stall; k++) begin
            check("stall_bus_req", {31'd0, bus_req}, 32'd0);
            @(posedge clk); #1;
        end
        cpu_we = 1'b0;
        a = (((t + stall) % 2) == 1) ? 0 : 1;
        exp_len = stall + 1 + a + 512;
        rdy_low = (stall > 0) ? 0 : 0;
        rdy_low = 0;
        for (int c = t; c <= t + exp_len; c++) begin
            @(negedge clk);
            if (retrig && (cyc - t) == 40) begin
                periph_sel = 1'b1; periph_we = 1'b1; periph_addr = 8'h14; periph_data = 8'h04;
            end else begin
                periph_idle();
            end
            exp_b = (cyc - t) < exp_len;
            if (!rdy) rdy_low++;
            check("rdy_window", {31'd0, rdy}, {31'd0, !exp_b});
            check("busy_window", {31'd0, busy}, {31'd0, exp_b});
        end
        periph_idle();
        check("first_read_cyc", first_read_cyc, t + stall + 1 + a);
        check("xfer_q_empty", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic no_action(input string name, input logic sel, input logic we, input logic [7:0] addr);
        @(negedge clk);
        periph_sel = sel; periph_we = we; periph_addr = addr; periph_data = 8'h07;
        @(negedge clk);
        periph_idle();
        repeat (3) begin
            @(negedge clk);
            check({name, "_rdy"}, {31'd0, rdy}, 32'd1);
            check({name, "_busy"}, {31'd0, busy}, 32'd0);
            check({name, "_bus_req"}, {31'd0, bus_req}, 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int p0, guard;
        logic [7:0] pg;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'h5A;
        n_reset = 1'b0; cpu_we = 1'b0;
        periph_idle();
        #12;
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_we", {31'd0, bus_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bus_addr", {16'd0, bus_addr}, 32'd0);
        @(negedge clk); n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // Copy test, then both phase alignments
        xfer(8'h03, 0, -1, 1'b0, len);
        check("after_copy_rdy", {31'd0, rdy}, 32'd1);
        xfer(8'h11, 0, 1, 1'b0, len);
        check("rdy_low_phase1", len, 32'd513);
        xfer(8'h22, 0, 0, 1'b0, len);
        check("rdy_low_phase0", len, 32'd514);
        xfer(8'h03, 3, -1, 1'b0, len);

        no_action("dec_addr15", 1'b1, 1'b1, 8'h15);
        no_action("dec_nosel", 1'b0, 1'b1, 8'h14);
        no_action("dec_read", 1'b1, 1'b0, 8'h14);

        // Page FF with an ignored retrigger mid-transfer
        xfer(8'hFF, 0, -1, 1'b1, len);

        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(8'($urandom), $urandom_range(0, 4), -1, 1'b0, len);
        end

        // Reset after byte 100's write
        @(negedge clk);
        periph_sel = 1'b1; periph_we = 1'b1; periph_addr = 8'h14; periph_data = 8'h05;
        push_xfer(8'h05);
        @(negedge clk);
        periph_idle();
        p0 = pops - 1;
        p0 = pops;
        guard = 0;
        while (pops < p0 + 202 && guard < 1000) begin
            @(negedge clk); #1;
            guard++;
        end
        check("reset_wait_bound", {31'd0, guard < 1000}, 32'd1);
        #1 n_reset = 1'b0;
        #1;
        check("mid_rst_rdy", {31'd0, rdy}, 32'd1);
        check("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_bus_addr", {16'd0, bus_addr}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        pg = 8'h02;
        xfer(pg, 0, -1, 1'b0, len);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
